// File: rtl/qpu_lsu_icb_ctrl.sv
// ICB slave between the LSU and the single-port data SRAM: buffers commands,
// range/alignment checks them, drives the SRAM and returns in-order responses.
module qpu_lsu_icb_ctrl #(
   parameter int unsigned           XLEN       = 32,
   parameter int unsigned           ADDR_SIZE  = 32,
   parameter int unsigned           RAM_AW     = 10,
   parameter logic [ADDR_SIZE-1:0]  RAM_BASE   = '0,
   parameter int unsigned           FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          icb_cmd_valid,
   output logic                          icb_cmd_ready,
   input  logic [ADDR_SIZE-1:0]          icb_cmd_addr,
   input  logic                          icb_cmd_read,
   input  logic [XLEN-1:0]               icb_cmd_wdata,
   input  logic [XLEN/8-1:0]             icb_cmd_wmask,
   output logic                          icb_rsp_valid,
   input  logic                          icb_rsp_ready,
   output logic [XLEN-1:0]               icb_rsp_rdata,
   output logic                          icb_rsp_err,
   output logic                          ram_cs,
   output logic                          ram_we,
   output logic [RAM_AW-1:0]             ram_addr,
   output logic [XLEN-1:0]               ram_wdata,
   output logic [XLEN/8-1:0]             ram_wem,
   input  logic [XLEN-1:0]               ram_dout,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          idle
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned MW = XLEN / 8;

   typedef struct packed {
      logic [ADDR_SIZE-1:0] addr;
      logic                 read;
      logic [XLEN-1:0]      wdata;
      logic [MW-1:0]        wmask;
   } cmd_t;

   cmd_t            mem_q [FIFO_DEPTH];
   cmd_t            head;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop, empty, full, head_err;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic            rsp_load_q, rsp_load_d;
   logic            rsp_first_q, rsp_first_d;
   logic [XLEN-1:0] hold_q, hold_d;
   logic [XLEN-1:0] rsp_rdata;

   assign empty         = (count_q == '0);
   assign full          = (count_q == CW'(FIFO_DEPTH));
   assign icb_cmd_ready = !full;
   assign push          = icb_cmd_valid & !full;
   assign pop           = !empty & (!rsp_valid_q | icb_rsp_ready);
   assign head          = mem_q[rd_ptr_q];

   // RAM_BASE is window-aligned, so the range check reduces to matching the upper bits
   assign head_err = (head.addr[1:0] != 2'b00) |
                     (head.addr[ADDR_SIZE-1:RAM_AW+2] != RAM_BASE[ADDR_SIZE-1:RAM_AW+2]);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{addr: icb_cmd_addr, read: icb_cmd_read,
                              wdata: icb_cmd_wdata, wmask: icb_cmd_wmask};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wem   = '0;
      if (pop && !head_err) begin
         ram_cs    = 1'b1;
         ram_we    = !head.read;
         ram_addr  = head.addr[RAM_AW+1:2];
         ram_wdata = head.wdata;
         ram_wem   = head.wmask;
      end
   end

   // First response cycle takes SRAM data live; later stalled cycles replay the hold copy
   assign rsp_rdata = rsp_first_q ? (rsp_load_q ? ram_dout : '0) : hold_q;

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_load_d  = rsp_load_q;
      rsp_first_d = 1'b0;
      hold_d      = hold_q;
      if (rsp_first_q) hold_d = rsp_rdata;
      if (pop) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = head_err;
         rsp_load_d  = head.read & !head_err;
         rsp_first_d = 1'b1;
      end else if (rsp_valid_q && icb_rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_load_q  <= 1'b0;
         rsp_first_q <= 1'b0;
         hold_q      <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_load_q  <= rsp_load_d;
         rsp_first_q <= rsp_first_d;
         hold_q      <= hold_d;
      end
   end

   assign icb_rsp_valid = rsp_valid_q;
   assign icb_rsp_err   = rsp_err_q;
   assign icb_rsp_rdata = rsp_rdata;
   assign fifo_count    = count_q;
   assign idle          = empty & !rsp_valid_q & !ram_cs;

endmodule

// File: tb/tb_qpu_lsu_icb_ctrl.sv
// Directed bench for qpu_lsu_icb_ctrl with an SRAM model and an in-order
// transaction-level reference model checked every cycle.
module tb_qpu_lsu_icb_ctrl;

   localparam logic [31:0] BASE     = 32'h0000_0000;
   localparam longint      WIN_SIZE = 4 * 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        icb_cmd_valid = 1'b0;
   logic        icb_cmd_ready;
   logic [31:0] icb_cmd_addr  = '0;
   logic        icb_cmd_read  = 1'b0;
   logic [31:0] icb_cmd_wdata = '0;
   logic [3:0]  icb_cmd_wmask = '0;
   logic        icb_rsp_valid;
   logic        icb_rsp_ready = 1'b1;
   logic [31:0] icb_rsp_rdata;
   logic        icb_rsp_err;
   logic        ram_cs, ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_wem;
   logic [31:0] ram_dout = '0;
   logic [1:0]  fifo_count;
   logic        idle;

   qpu_lsu_icb_ctrl #(
      .XLEN(32), .ADDR_SIZE(32), .RAM_AW(10), .RAM_BASE(BASE), .FIFO_DEPTH(2)
   ) dut (
      .clk(clk), .rst(rst),
      .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
      .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
      .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
      .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_wem(ram_wem), .ram_dout(ram_dout),
      .fifo_count(fifo_count), .idle(idle)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int stall_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct { logic err; logic [31:0] rdata; } rsp_t;
   typedef struct { logic [9:0] addr; logic we; logic [31:0] wdata; logic [3:0] wem; } acc_t;

   rsp_t        exp_q[$];
   acc_t        acc_q[$];
   rsp_t        resp_log[$];
   int          hs_log[$], cs_log[$], rv_log[$], rh_log[$];
   logic [31:0] ref_mem [1024];
   logic [31:0] sram    [1024];

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: one-cycle read latency, byte-masked writes
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end else begin
            ram_dout <= sram[ram_addr];
         end
      end
   end

   acc_t        mon_a;
   logic        mon_err;
   int unsigned mon_idx;

   // Reference model: every accepted command yields exactly one response, in order
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
      end else begin
         if (ram_cs) begin
            cs_log.push_back(cyc);
            if (acc_q.size() == 0) check("ram_cs_unexpected", 32'(ram_cs), 32'd0);
            else begin
               mon_a = acc_q.pop_front();
               check("ram_addr", 32'(ram_addr), 32'(mon_a.addr));
               check("ram_we", 32'(ram_we), 32'(mon_a.we));
               if (mon_a.we) begin
                  check("ram_wdata", ram_wdata, mon_a.wdata);
                  check("ram_wem", 32'(ram_wem), 32'(mon_a.wem));
               end
            end
         end
         if (icb_rsp_valid) begin
            rv_log.push_back(cyc);
            if (exp_q.size() == 0) check("rsp_unexpected", 32'(icb_rsp_valid), 32'd0);
            else begin
               check("rsp_err", 32'(icb_rsp_err), 32'(exp_q[0].err));
               check("rsp_rdata", icb_rsp_rdata, exp_q[0].rdata);
               if (icb_rsp_ready) begin
                  resp_log.push_back('{err: icb_rsp_err, rdata: icb_rsp_rdata});
                  rh_log.push_back(cyc);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (icb_cmd_valid && !icb_cmd_ready) stall_cnt <= stall_cnt + 1;
         if (icb_cmd_valid && icb_cmd_ready) begin
            hs_log.push_back(cyc);
            mon_err = (icb_cmd_addr % 4 != 0) || (longint'(icb_cmd_addr) < longint'(BASE)) ||
                      (longint'(icb_cmd_addr) >= longint'(BASE) + WIN_SIZE);
            mon_idx = (icb_cmd_addr - BASE) / 4;
            if (mon_err) begin
               exp_q.push_back('{err: 1'b1, rdata: 32'd0});
            end else if (icb_cmd_read) begin
               exp_q.push_back('{err: 1'b0, rdata: ref_mem[mon_idx[9:0]]});
               acc_q.push_back('{addr: mon_idx[9:0], we: 1'b0, wdata: icb_cmd_wdata, wem: icb_cmd_wmask});
            end else begin
               for (int b = 0; b < 4; b++)
                  if (icb_cmd_wmask[b]) ref_mem[mon_idx[9:0]][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
               exp_q.push_back('{err: 1'b0, rdata: 32'd0});
               acc_q.push_back('{addr: mon_idx[9:0], we: 1'b1, wdata: icb_cmd_wdata, wem: icb_cmd_wmask});
            end
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [3:0] wm);
      bit done = 1'b0;
      icb_cmd_valid = 1'b1;
      icb_cmd_addr  = a;
      icb_cmd_read  = rd;
      icb_cmd_wdata = wd;
      icb_cmd_wmask = wm;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (icb_cmd_ready) done = 1'b1;
         @(posedge clk); #1;
      end
      icb_cmd_valid = 1'b0;
      if (!done) check("cmd_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (idle && exp_q.size() == 0) ok = 1'b1;
         @(posedge clk); #1;
      end
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   int b_rsp, b_hs, b_cs, b_rv, b_rh, b_st;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         sram[i]    = 32'hC0DE_0000 | 32'(i);
         ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      end

      // reset state
      repeat (2) @(negedge clk);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
      check("rst_rsp_rdata", icb_rsp_rdata, 32'd0);
      check("rst_ram_cs", 32'(ram_cs), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // store then load 0x10
      b_rsp = resp_log.size();
      send(32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      check("st_ram_cs", 32'(ram_cs), 32'd1);
      check("st_ram_we", 32'(ram_we), 32'd1);
      check("st_ram_addr", 32'(ram_addr), 32'd4);
      @(posedge clk); #1;
      send(32'h10, 1'b1, 32'h0, 4'h0);
      wait_idle();
      check("t1_n_rsp", 32'(resp_log.size() - b_rsp), 32'd2);
      check("t1_st_err", 32'(resp_log[b_rsp].err), 32'd0);
      check("t1_st_rdata", resp_log[b_rsp].rdata, 32'd0);
      check("t1_ld_err", 32'(resp_log[b_rsp+1].err), 32'd0);
      check("t1_ld_rdata", resp_log[b_rsp+1].rdata, 32'hDEAD_BEEF);

      // three back-to-back loads
      b_rsp = resp_log.size(); b_hs = hs_log.size(); b_cs = cs_log.size();
      b_rv = rv_log.size(); b_st = stall_cnt;
      send(32'h40, 1'b1, 32'h0, 4'h0);
      send(32'h44, 1'b1, 32'h0, 4'h0);
      send(32'h48, 1'b1, 32'h0, 4'h0);
      wait_idle();
      check("t2_n_cs", 32'(cs_log.size() - b_cs), 32'd3);
      check("t2_n_rv", 32'(rv_log.size() - b_rv), 32'd3);
      check("t2_cs_lat", 32'(cs_log[b_cs] - hs_log[b_hs]), 32'd1);
      check("t2_cs_b2b_a", 32'(cs_log[b_cs+1] - cs_log[b_cs]), 32'd1);
      check("t2_cs_b2b_b", 32'(cs_log[b_cs+2] - cs_log[b_cs+1]), 32'd1);
      check("t2_rv_lat", 32'(rv_log[b_rv] - hs_log[b_hs]), 32'd2);
      check("t2_rv_b2b_a", 32'(rv_log[b_rv+1] - rv_log[b_rv]), 32'd1);
      check("t2_rv_b2b_b", 32'(rv_log[b_rv+2] - rv_log[b_rv+1]), 32'd1);
      check("t2_no_stall", 32'(stall_cnt - b_st), 32'd0);
      check("t2_rdata0", resp_log[b_rsp].rdata, 32'hC0DE_0010);
      check("t2_rdata2", resp_log[b_rsp+2].rdata, 32'hC0DE_0012);

      // backpressure: 4 loads offered with rsp_ready low
      send(32'h20, 1'b0, 32'h1111_1111, 4'hF);
      send(32'h24, 1'b0, 32'h2222_2222, 4'hF);
      send(32'h28, 1'b0, 32'h3333_3333, 4'hF);
      send(32'h2C, 1'b0, 32'h4444_4444, 4'hF);
      wait_idle();
      icb_rsp_ready = 1'b0;
      b_rsp = resp_log.size(); b_hs = hs_log.size(); b_rh = rh_log.size();
      send(32'h20, 1'b1, 32'h0, 4'h0);
      send(32'h24, 1'b1, 32'h0, 4'h0);
      send(32'h28, 1'b1, 32'h0, 4'h0);
      icb_cmd_valid = 1'b1; icb_cmd_addr = 32'h2C; icb_cmd_read = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_cmd_ready", 32'(icb_cmd_ready), 32'd0);
         check("bp_fifo_count", 32'(fifo_count), 32'd2);
         check("bp_rsp_valid", 32'(icb_rsp_valid), 32'd1);
         check("bp_rdata_hold", icb_rsp_rdata, 32'h1111_1111);
         @(posedge clk); #1;
      end
      check("bp_n_accepted", 32'(hs_log.size() - b_hs), 32'd3);
      icb_rsp_ready = 1'b1;
      send(32'h2C, 1'b1, 32'h0, 4'h0);
      wait_idle();
      check("bp_rd0", resp_log[b_rsp].rdata, 32'h1111_1111);
      check("bp_rd1", resp_log[b_rsp+1].rdata, 32'h2222_2222);
      check("bp_rd2", resp_log[b_rsp+2].rdata, 32'h3333_3333);
      check("bp_rd3", resp_log[b_rsp+3].rdata, 32'h4444_4444);
      check("bp_drain_a", 32'(rh_log[b_rh+1] - rh_log[b_rh]), 32'd1);
      check("bp_drain_b", 32'(rh_log[b_rh+2] - rh_log[b_rh+1]), 32'd1);
      check("bp_drain_c", 32'(rh_log[b_rh+3] - rh_log[b_rh+2]), 32'd1);

      // misaligned and out-of-range, then a good load
      b_rsp = resp_log.size(); b_cs = cs_log.size();
      send(32'h12, 1'b1, 32'h0, 4'h0);
      send(32'h1000, 1'b1, 32'h0, 4'h0);
      send(32'h0, 1'b1, 32'h0, 4'h0);
      wait_idle();
      check("err_n_cs", 32'(cs_log.size() - b_cs), 32'd1);
      check("err_mis_err", 32'(resp_log[b_rsp].err), 32'd1);
      check("err_mis_rdata", resp_log[b_rsp].rdata, 32'd0);
      check("err_oor_err", 32'(resp_log[b_rsp+1].err), 32'd1);
      check("err_oor_rdata", resp_log[b_rsp+1].rdata, 32'd0);
      check("err_good_err", 32'(resp_log[b_rsp+2].err), 32'd0);
      check("err_good_rdata", resp_log[b_rsp+2].rdata, 32'hC0DE_0000);

      // partial byte mask store
      b_rsp = resp_log.size();
      send(32'h30, 1'b0, 32'hCAFE_F00D, 4'b0101);
      @(negedge clk);
      check("wm_ram_cs", 32'(ram_cs), 32'd1);
      check("wm_ram_wem", 32'(ram_wem), 32'h5);
      check("wm_ram_wdata", ram_wdata, 32'hCAFE_F00D);
      @(posedge clk); #1;
      send(32'h30, 1'b1, 32'h0, 4'h0);
      wait_idle();
      check("wm_readback", resp_log[b_rsp+1].rdata, 32'hC0FE_000D);

      // asynchronous reset with a full FIFO and a read in flight
      icb_rsp_ready = 1'b0;
      send(32'h50, 1'b1, 32'h0, 4'h0);
      send(32'h54, 1'b1, 32'h0, 4'h0);
      send(32'h58, 1'b1, 32'h0, 4'h0);
      icb_rsp_ready = 1'b1;
      @(negedge clk);
      check("mr_pre_count", 32'(fifo_count), 32'd2);
      check("mr_pre_cs", 32'(ram_cs), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mr_rsp_valid", 32'(icb_rsp_valid), 32'd0);
      check("mr_ram_cs", 32'(ram_cs), 32'd0);
      check("mr_ram_addr", 32'(ram_addr), 32'd0);
      check("mr_fifo_count", 32'(fifo_count), 32'd0);
      check("mr_rdata", icb_rsp_rdata, 32'd0);
      check("mr_idle", 32'(idle), 32'd1);
      @(posedge clk); @(negedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mr_post_idle", 32'(idle), 32'd1);
      check("mr_post_ready", 32'(icb_cmd_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         check("mr_no_stale_rsp", 32'(icb_rsp_valid), 32'd0);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/qpu_lsu_icb_ctrl.md
Name: qpu_lsu_icb_ctrl

Overview:
- Sits directly downstream of the LSU and consumes its ICB command channel.
- Buffers commands in a small FIFO, checks address range and alignment, and drives the single-port synchronous data SRAM.
- Returns one ICB response per command, carrying read data and an error flag.
- The LSU keeps rsp_ready tied high, but this block honours rsp_ready fully.

Parameters:
- XLEN, 32, data width; must equal QPU_XLEN.
- ADDR_SIZE, 32, ICB address width; must equal QPU_ADDR_SIZE.
- RAM_AW, 10, SRAM word-address width (2^RAM_AW words).
- RAM_BASE, 32'h0000_0000, byte base address of the SRAM window; aligned to 4*2^RAM_AW.
- FIFO_DEPTH, 2, command FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- icb_cmd_valid  in  1  command valid from LSU
- icb_cmd_ready  out  1  command ready to LSU
- icb_cmd_addr  in  ADDR_SIZE  byte address
- icb_cmd_read  in  1  1 = load, 0 = store
- icb_cmd_wdata  in  XLEN  store data
- icb_cmd_wmask  in  XLEN/8  byte write enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response ready
- icb_rsp_rdata  out  XLEN  load data; 0 for stores and errors
- icb_rsp_err  out  1  address error flag
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_addr  out  RAM_AW  SRAM word address
- ram_wdata  out  XLEN  SRAM write data
- ram_wem  out  XLEN/8  SRAM byte write mask
- ram_dout  in  XLEN  SRAM read data, valid the cycle after ram_cs with ram_we=0
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- idle  out  1  FIFO empty, no response pending, no SRAM access in flight

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empties; pointers and count go to 0.
  - icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0.
  - ram_cs=0, ram_we=0; ram_addr, ram_wdata and ram_wem go to 0.
  - idle=1.
- Command acceptance:
  - icb_cmd_ready = (count != FIFO_DEPTH), purely from registered state, with no combinational path from icb_rsp_ready.
  - Push on valid & ready; the entry stores addr, read, wdata and wmask.
- Issue (pop) condition: FIFO non-empty AND (rsp slot empty OR rsp handshake this cycle).
- On pop, the head is decoded combinationally.
  - err = (addr[1:0] != 0) OR addr outside [RAM_BASE, RAM_BASE + 4*2^RAM_AW).
  - If err=0: ram_cs=1 for exactly that cycle, ram_we = !read, ram_addr = addr[RAM_AW+1:2]; wdata/wmask pass through.
  - If err=1: ram_cs stays 0 and the SRAM is not touched.
- Response:
  - The cycle after a pop, icb_rsp_valid=1 and icb_rsp_err=err.
  - icb_rsp_rdata = ram_dout for a good load; 0 for a store or an error.
  - Read data comes from ram_dout in the first valid cycle and is captured into a hold register.
  - While valid & !ready, every response output holds stable from the hold register, and no further pop occurs.
- Latency and throughput:
  - Empty FIFO: cmd handshake at cycle T, SRAM access at T+1, icb_rsp_valid at T+2.
  - With rsp_ready=1 the sustained throughput is one command per cycle.
- Ordering: responses return strictly in command order, one response per command.
- Boundary conditions:
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push is impossible when full; pop is impossible when empty.
  - A response handshake and a new pop in the same cycle must give a back-to-back icb_rsp_valid with no bubble.
- Mid-operation reset: all FIFO entries are discarded, and any SRAM read in flight produces no response.
- idle = (count==0) & !icb_rsp_valid & !ram_cs.

Test Plan:
- Store addr 0x10, wdata 0xDEADBEEF, wmask 4'hF, then load 0x10, rsp_ready=1:
  - Store: ram_cs/ram_we=1, ram_addr=4.
  - Two responses with err=0; the second has rdata=0xDEADBEEF.
  - Store response rdata=0.
- Three back-to-back loads, rsp_ready=1: ram_cs high on 3 consecutive cycles; icb_rsp_valid high on 3 consecutive cycles starting 2 cycles after the first handshake; icb_cmd_ready never drops.
- rsp_ready=0 with 4 loads offered:
  - One response pends, FIFO reaches count=2, icb_cmd_ready=0, only 3 commands accepted.
  - icb_rsp_rdata stays stable for 5 cycles.
  - After raising rsp_ready, the responses drain in order at 1/cycle, and the 4th command is accepted once ready rises.
- Load 0x12 (misaligned) and load at RAM_BASE+0x1000 with RAM_AW=10 (out of range): both give err=1 and rdata=0, ram_cs never asserts; a following good load to 0x0 still returns err=0.
- Store with wmask 4'b0101: ram_wem=4'b0101 and ram_wdata passes through unchanged.
- Assert rst while FIFO count=2 and a read is in flight:
  - Outputs go to reset values asynchronously and no stale response appears after release.
  - idle=1 and icb_cmd_ready=1 the first cycle after release.
